// File: rtl/phase_monitor.sv
// rtl/phase_monitor.sv - two-phase clock checker: edge strobes, order/overlap/toggle/liveness checks, lock
// Phases are sampled in the master clock domain; every check and the lock FSM run from one edge.
module phase_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 8,
  parameter int CNT_W      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clk1,
  input  logic             i_clk2,
  input  logic             i_o_s,
  input  logic             i_clr_err,
  output logic             o_ph1_stb,
  output logic             o_ph2_stb,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_period,
  output logic             o_err_ovl,
  output logic             o_err_seq,
  output logic             o_err_tmo,
  output logic             o_err_os
);

  localparam int PW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0]    LOCK_VAL = PW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP2 = 2'd1,
    EXP1 = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_c1_q;
  logic             r_c2_q;
  logic             r_os_q;
  logic             r_os_valid;
  logic [PW-1:0]    r_pair;
  logic [PW-1:0]    w_pair_nxt;
  logic [PW-1:0]    w_pair_inc;
  logic             w_locked_nxt;
  logic             w_per_upd;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_gap_inc;
  logic [CNT_W-1:0] r_per_cnt;
  logic             w_r1;
  logic             w_r2;
  logic             w_any;
  logic             w_ovl;
  logic             w_seq;
  logic             w_tmo;
  logic             w_os;
  logic             w_fault;

  assign w_r1  = i_clk1 & ~r_c1_q;
  assign w_r2  = i_clk2 & ~r_c2_q;
  assign w_any = w_r1 | w_r2;

  assign w_gap_inc  = (r_gap == CNT_MAX) ? r_gap : r_gap + 1'b1;
  assign w_pair_inc = (r_pair == LOCK_VAL) ? r_pair : r_pair + 1'b1;

  // Checks are mutually exclusive by priority: only the strongest one raises its flag.
  assign w_ovl = i_clk1 & i_clk2;
  assign w_seq = ~w_ovl & ((w_r1 & (r_state == EXP2)) | (w_r2 & (r_state == EXP1)));
  assign w_tmo = ~w_ovl & ~w_seq & (r_state != HUNT) & ~w_any & (w_gap_inc >= TMO_VAL);
  assign w_os  = ~w_ovl & ~w_seq & ~w_tmo & w_any & (r_state != HUNT) &
                 r_os_valid & (i_o_s == r_os_q);
  assign w_fault = w_ovl | w_seq | w_tmo;

  always_comb begin
    w_state_nxt  = r_state;
    w_pair_nxt   = r_pair;
    w_locked_nxt = o_locked;
    w_per_upd    = 1'b0;
    if (w_fault) begin
      w_state_nxt  = HUNT;
      w_pair_nxt   = '0;
      w_locked_nxt = 1'b0;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_r1) w_state_nxt = EXP2;
        end
        EXP2: begin
          if (w_r2) begin
            w_state_nxt = EXP1;
            w_pair_nxt  = w_pair_inc;
            if (w_pair_inc == LOCK_VAL) w_locked_nxt = 1'b1;
          end
        end
        EXP1: begin
          if (w_r1) begin
            w_state_nxt = EXP2;
            w_per_upd   = 1'b1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= HUNT;
      r_pair     <= '0;
      o_locked   <= 1'b0;
      r_c1_q     <= 1'b0;
      r_c2_q     <= 1'b0;
      o_ph1_stb  <= 1'b0;
      o_ph2_stb  <= 1'b0;
      r_gap      <= '0;
      r_per_cnt  <= '0;
      o_period   <= '0;
      r_os_q     <= 1'b0;
      r_os_valid <= 1'b0;
      o_err_ovl  <= 1'b0;
      o_err_seq  <= 1'b0;
      o_err_tmo  <= 1'b0;
      o_err_os   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pair    <= w_pair_nxt;
      o_locked  <= w_locked_nxt;
      r_c1_q    <= i_clk1;
      r_c2_q    <= i_clk2;
      o_ph1_stb <= w_r1;
      o_ph2_stb <= w_r2;

      // Idle time in HUNT is not liveness-relevant, so the gap counter stays parked there.
      if (w_fault || w_any || (r_state == HUNT)) r_gap <= '0;
      else                                       r_gap <= w_gap_inc;

      if (w_r1)                        r_per_cnt <= CNT_W'(1);
      else if (r_per_cnt != CNT_MAX)   r_per_cnt <= r_per_cnt + 1'b1;
      if (w_per_upd)                   o_period  <= r_per_cnt;

      if (w_state_nxt == HUNT) begin
        r_os_valid <= 1'b0;
      end else if (w_any) begin
        r_os_q     <= i_o_s;
        r_os_valid <= 1'b1;
      end

      o_err_ovl <= (o_err_ovl & ~i_clr_err) | w_ovl;
      o_err_seq <= (o_err_seq & ~i_clr_err) | w_seq;
      o_err_tmo <= (o_err_tmo & ~i_clr_err) | w_tmo;
      o_err_os  <= (o_err_os  & ~i_clr_err) | w_os;
    end
  end

endmodule

// File: tb/tb_phase_monitor.sv
// tb/tb_phase_monitor.sv - directed vector bench for phase_monitor
module tb_phase_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk1, clk2, o_s, clr_err;
  logic       ph1_stb, ph2_stb, locked;
  logic [7:0] period;
  logic       err_ovl, err_seq, err_tmo, err_os;
  logic [14:0] w_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic tb_os;

  phase_monitor #(.LOCK_COUNT(4), .TIMEOUT(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk1(clk1), .i_clk2(clk2), .i_o_s(o_s),
    .i_clr_err(clr_err), .o_ph1_stb(ph1_stb), .o_ph2_stb(ph2_stb), .o_locked(locked),
    .o_period(period), .o_err_ovl(err_ovl), .o_err_seq(err_seq), .o_err_tmo(err_tmo),
    .o_err_os(err_os)
  );

  always #5 clk = ~clk;

  assign w_out = {ph1_stb, ph2_stb, locked, err_ovl, err_seq, err_tmo, err_os, period};

  typedef struct {
    logic        c1;
    logic        c2;
    logic        os;
    logic [14:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic c1, input logic c2, input logic os,
                              input logic [6:0] fl, input logic [7:0] per);
    vec_t v;
    v.c1 = c1; v.c2 = c2; v.os = os; v.exp = {fl, per};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic c1, input logic c2, input logic os, input logic clr);
    clk1 = c1; clk2 = c2; o_s = os; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic good_pair();
    tb_os = ~tb_os;
    drive(1'b1, 1'b0, tb_os, 1'b0);
    drive(1'b0, 1'b0, tb_os, 1'b0);
    tb_os = ~tb_os;
    drive(1'b0, 1'b1, tb_os, 1'b0);
    drive(1'b0, 1'b0, tb_os, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // flags: {ph1, ph2, locked, ovl, seq, tmo, os}
    tbl[0]  = mk(1, 0, 1, 7'b1000000, 8'd0);
    tbl[1]  = mk(0, 0, 1, 7'b0000000, 8'd0);
    tbl[2]  = mk(0, 1, 0, 7'b0100000, 8'd0);
    tbl[3]  = mk(0, 0, 0, 7'b0000000, 8'd0);
    tbl[4]  = mk(1, 0, 1, 7'b1000000, 8'd4);
    tbl[5]  = mk(0, 0, 1, 7'b0000000, 8'd4);
    tbl[6]  = mk(0, 1, 0, 7'b0100000, 8'd4);
    tbl[7]  = mk(0, 0, 0, 7'b0000000, 8'd4);
    tbl[8]  = mk(1, 0, 1, 7'b1000000, 8'd4);
    tbl[9]  = mk(0, 0, 1, 7'b0000000, 8'd4);
    tbl[10] = mk(0, 1, 0, 7'b0100000, 8'd4);
    tbl[11] = mk(0, 0, 0, 7'b0000000, 8'd4);
    tbl[12] = mk(1, 0, 1, 7'b1000000, 8'd4);
    tbl[13] = mk(0, 0, 1, 7'b0000000, 8'd4);
    tbl[14] = mk(0, 1, 0, 7'b0110000, 8'd4);
    tbl[15] = mk(0, 0, 0, 7'b0010000, 8'd4);

    rst_n = 1'b0; clk1 = 0; clk2 = 0; o_s = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", w_out, 15'd0);
    rst_n = 1'b1;

    // T1 nominal pattern
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].c1, tbl[i].c2, tbl[i].os, 1'b0);
      chk($sformatf("t1_vec%0d", i), w_out, tbl[i].exp);
    end
    tb_os = 1'b0;

    // T2 overlap while locked, relock, then clear
    tb_os = ~tb_os;
    drive(1'b1, 1'b1, tb_os, 1'b0);
    chk("t2_ovl_edge", w_out[14:8], 7'b1101000);
    drive(1'b0, 1'b0, tb_os, 1'b0);
    chk("t2_ovl_hold", w_out[14:8], 7'b0001000);
    repeat (3) good_pair();
    chk("t2_not_yet_locked", locked, 1'b0);
    good_pair();
    chk("t2_relocked", locked, 1'b1);
    chk("t2_ovl_sticky", err_ovl, 1'b1);
    chk("t2_period", period, 8'd4);
    drive(1'b0, 1'b0, tb_os, 1'b1);
    chk("t2_clr", w_out[14:8], 7'b0010000);

    // T3 skipped CLK2
    tb_os = ~tb_os;
    drive(1'b1, 1'b0, tb_os, 1'b0);
    drive(1'b0, 1'b0, tb_os, 1'b0);
    tb_os = ~tb_os;
    drive(1'b1, 1'b0, tb_os, 1'b0);
    chk("t3_seq", w_out[14:8], 7'b1000100);
    drive(1'b0, 1'b0, tb_os, 1'b0);
    repeat (4) good_pair();
    chk("t3_relocked", w_out[14:8], 7'b0010100);
    drive(1'b0, 1'b0, tb_os, 1'b1);
    chk("t3_clr", err_seq, 1'b0);

    // T4 stall: eight low cycles after the last CLK2
    good_pair();
    repeat (6) drive(1'b0, 1'b0, tb_os, 1'b0);
    chk("t4_before_tmo", w_out[14:8], 7'b0010000);
    drive(1'b0, 1'b0, tb_os, 1'b0);
    chk("t4_tmo", w_out[14:8], 7'b0000010);

    // T5 O_S stuck high from a fresh start
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_first_rise", err_os, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_second_rise", w_out[14:8], 7'b0100001);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("t5_locked", w_out, {7'b0010001, 8'd4});

    // T6 async reset mid-pattern, then clear racing a new overlap
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_reset_stb", ph1_stb, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", w_out, 15'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_ovl_set", err_ovl, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_clr_only", err_ovl, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_clr_vs_ovl", err_ovl, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
